// File: rtl/cle_param.sv
// Connected-component labeller: loads a packed bitmap from ROM, raster-scans it and
// BFS-floods each new object, writing exactly one label per pixel to SRAM.
module cle_param #(
    parameter  int IMG_W   = 32,
    parameter  int IMG_H   = 32,
    parameter  int ROM_DW  = 8,
    parameter  int LABEL_W = 8,
    localparam int NPIX    = IMG_W * IMG_H,
    localparam int ROM_AW  = $clog2(NPIX / ROM_DW),
    localparam int SRAM_AW = $clog2(NPIX)
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_conn8,
    output logic [ROM_AW-1:0]  o_rom_a,
    input  logic [ROM_DW-1:0]  i_rom_q,
    output logic [SRAM_AW-1:0] o_sram_a,
    output logic [LABEL_W-1:0] o_sram_d,
    output logic               o_sram_wen,
    output logic               o_busy,
    output logic               o_finish,
    output logic [LABEL_W-1:0] o_label_count,
    output logic               o_overflow
);
    localparam logic [2:0] S_IDLE = 3'd0, S_LOAD = 3'd1, S_SCAN = 3'd2,
                           S_POP  = 3'd3, S_NBR  = 3'd4, S_DONE = 3'd5;
    localparam logic [ROM_AW:0]    NWORD = (ROM_AW+1)'(NPIX / ROM_DW);
    localparam logic [SRAM_AW:0]   PEND  = (SRAM_AW+1)'(NPIX);
    localparam logic [SRAM_AW-1:0] PLAST = SRAM_AW'(NPIX - 1);
    localparam logic [LABEL_W-1:0] LMAX  = '1;

    logic [2:0]         r_state;
    logic [ROM_AW:0]    r_cnt;
    logic [NPIX-1:0]    r_bmp, r_vis;
    logic [SRAM_AW:0]   r_p, r_head, r_tail;
    logic [SRAM_AW-1:0] r_mem [NPIX];
    logic [SRAM_AW-1:0] r_q;
    logic [2:0]         r_k;
    logic               r_conn8;
    logic [LABEL_W-1:0] r_lbl, r_lcnt;
    logic               r_ovf;

    logic [SRAM_AW-1:0] w_pidx, w_nidx, w_enq_idx;
    logic [ROM_AW-1:0]  w_ld_word;
    logic               w_nvalid, w_new, w_hit, w_enq, w_last, w_start;
    logic [LABEL_W-1:0] w_newlbl;

    assign w_pidx    = r_p[SRAM_AW-1:0];
    assign w_ld_word = ROM_AW'(r_cnt - 1'b1);
    assign w_start   = i_start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_new     = (r_state == S_SCAN) && r_bmp[w_pidx] && !r_vis[w_pidx];
    assign w_hit     = (r_state == S_NBR) && w_nvalid && r_bmp[w_nidx] && !r_vis[w_nidx];
    assign w_enq     = w_new || w_hit;
    assign w_enq_idx = w_new ? w_pidx : w_nidx;
    assign w_last    = r_conn8 ? (r_k == 3'd7) : (r_k == 3'd3);
    assign w_newlbl  = (r_lcnt == LMAX) ? LMAX : r_lcnt + 1'b1;

    // Neighbour order N, W, E, S, NW, NE, SW, SE; bounds are checked in x/y so rows never wrap.
    always_comb begin
        int dx, dy, nx, ny;
        dx = 0;
        dy = 0;
        case (r_k)
            3'd0:    dy = -1;
            3'd1:    dx = -1;
            3'd2:    dx = 1;
            3'd3:    dy = 1;
            3'd4:    begin dx = -1; dy = -1; end
            3'd5:    begin dx = 1;  dy = -1; end
            3'd6:    begin dx = -1; dy = 1;  end
            default: begin dx = 1;  dy = 1;  end
        endcase
        nx       = int'(r_q) % IMG_W + dx;
        ny       = int'(r_q) / IMG_W + dy;
        w_nvalid = (nx >= 0) && (nx < IMG_W) && (ny >= 0) && (ny < IMG_H);
        w_nidx   = SRAM_AW'(ny * IMG_W + nx);
    end

    // Unvisited pixels in SCAN are either background (label 0) or a new component's seed.
    always_comb begin
        o_sram_a   = '0;
        o_sram_d   = '0;
        o_sram_wen = 1'b1;
        if (r_state == S_SCAN && !r_vis[w_pidx]) begin
            o_sram_wen = 1'b0;
            o_sram_a   = w_pidx;
            o_sram_d   = r_bmp[w_pidx] ? w_newlbl : '0;
        end else if (w_hit) begin
            o_sram_wen = 1'b0;
            o_sram_a   = w_nidx;
            o_sram_d   = r_lbl;
        end
    end

    assign o_rom_a       = r_cnt[ROM_AW-1:0];
    assign o_busy        = (r_state == S_LOAD) || (r_state == S_SCAN) ||
                           (r_state == S_POP)  || (r_state == S_NBR);
    assign o_finish      = (r_state == S_DONE);
    assign o_label_count = r_lcnt;
    assign o_overflow    = r_ovf;

    always_ff @(posedge i_clk) begin
        if (w_enq) r_mem[r_tail[SRAM_AW-1:0]] <= w_enq_idx;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bmp   <= '0;
            r_vis   <= '0;
            r_p     <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_q     <= '0;
            r_k     <= '0;
            r_conn8 <= 1'b0;
            r_lbl   <= '0;
            r_lcnt  <= '0;
            r_ovf   <= 1'b0;
        end else if (w_start) begin
            r_conn8 <= i_conn8;
            r_lcnt  <= '0;
            r_ovf   <= 1'b0;
            r_vis   <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_cnt   <= '0;
            r_state <= S_LOAD;
        end else begin
            case (r_state)
                S_LOAD: begin
                    // ROM is one cycle behind the address, so word r_cnt-1 arrives now.
                    if (r_cnt != '0) r_bmp[int'(w_ld_word)*ROM_DW +: ROM_DW] <= i_rom_q;
                    if (r_cnt == NWORD) begin
                        r_cnt   <= '0;
                        r_p     <= '0;
                        r_state <= S_SCAN;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_SCAN: begin
                    r_p <= r_p + 1'b1;
                    if (w_new) begin
                        r_vis[w_pidx] <= 1'b1;
                        r_tail        <= r_tail + 1'b1;
                        r_lbl         <= w_newlbl;
                        if (r_lcnt == LMAX) r_ovf <= 1'b1;
                        else                r_lcnt <= w_newlbl;
                        r_state <= S_POP;
                    end else if (w_pidx == PLAST) begin
                        r_state <= S_DONE;
                    end
                end
                S_POP: begin
                    r_q     <= r_mem[r_head[SRAM_AW-1:0]];
                    r_head  <= r_head + 1'b1;
                    r_k     <= '0;
                    r_state <= S_NBR;
                end
                S_NBR: begin
                    if (w_hit) begin
                        r_vis[w_nidx] <= 1'b1;
                        r_tail        <= r_tail + 1'b1;
                    end
                    if (w_last) begin
                        if (w_hit || r_head != r_tail) r_state <= S_POP;
                        else if (r_p == PEND)          r_state <= S_DONE;
                        else                           r_state <= S_SCAN;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                S_IDLE, S_DONE: ;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cle_param.sv
// Directed bench for cle_param: a 32x32/8-bit-ROM instance driven from a vector table and
// a 16x8/16-bit-ROM instance for the reset-abort sequence, with ROM and SRAM models.
module tb_cle_param;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       st1, c81, st2, c82;
    logic [6:0] rom_a1;
    logic [7:0] rom_q1;
    logic [9:0] sa1;
    logic [7:0] sd1, lc1;
    logic       wen1, busy1, fin1, ovf1;
    logic [2:0]  rom_a2;
    logic [15:0] rom_q2;
    logic [6:0]  sa2;
    logic [7:0]  sd2, lc2;
    logic        wen2, busy2, fin2, ovf2;

    cle_param u_dut1 (
        .i_clk(clk), .i_reset(rst), .i_start(st1), .i_conn8(c81),
        .o_rom_a(rom_a1), .i_rom_q(rom_q1), .o_sram_a(sa1), .o_sram_d(sd1),
        .o_sram_wen(wen1), .o_busy(busy1), .o_finish(fin1),
        .o_label_count(lc1), .o_overflow(ovf1));

    cle_param #(.IMG_W(16), .IMG_H(8), .ROM_DW(16), .LABEL_W(8)) u_dut2 (
        .i_clk(clk), .i_reset(rst), .i_start(st2), .i_conn8(c82),
        .o_rom_a(rom_a2), .i_rom_q(rom_q2), .o_sram_a(sa2), .o_sram_d(sd2),
        .o_sram_wen(wen2), .o_busy(busy2), .o_finish(fin2),
        .o_label_count(lc2), .o_overflow(ovf2));

    bit         img  [1024];
    logic [7:0] lbl  [1024];
    int         wcnt [1024];
    logic       clr;
    int nchk = 0, nfail = 0;

    // Synchronous ROM and write-recording SRAM shared by both instances (only one runs at a time).
    always @(posedge clk) begin
        for (int i = 0; i < 8; i++)  rom_q1[i] <= img[int'(rom_a1)*8 + i];
        for (int i = 0; i < 16; i++) rom_q2[i] <= img[int'(rom_a2)*16 + i];
        if (clr) begin
            for (int i = 0; i < 1024; i++) begin
                wcnt[i] <= 0;
                lbl[i]  <= 8'hAA;
            end
        end else begin
            if (!wen1) begin lbl[sa1] <= sd1; wcnt[sa1] <= wcnt[sa1] + 1; end
            if (!wen2) begin lbl[sa2] <= sd2; wcnt[sa2] <= wcnt[sa2] + 1; end
        end
    end

    typedef struct {
        int pat, c8, cnt, ovf, uni, nmax, pa0, pl0, pa1, pl1;
    } vec_t;
    vec_t v [9];

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic build(input int pat, input int w, input int h);
        for (int i = 0; i < 1024; i++) img[i] = 1'b0;
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++)
                case (pat)
                    1: img[y*w+x] = 1'b1;
                    2: img[y*w+x] = (x == y) && (x < 2);
                    3: img[y*w+x] = (y*w+x == 31) || (y*w+x == 32);
                    4: img[y*w+x] = ((x + y) % 2) == 0;
                    5: img[y*w+x] = ((x == 2 || x == 6) && y >= 1 && y <= 5) ||
                                    (y == 5 && x >= 2 && x <= 6);
                    default: img[y*w+x] = 1'b0;
                endcase
    endtask

    task automatic clear_mem();
        @(negedge clk) clr = 1'b1;
        @(negedge clk) clr = 1'b0;
    endtask

    task automatic pulse_start(input int inst, input int c8);
        @(negedge clk);
        if (inst == 1) begin st1 = 1'b1; c81 = c8[0]; end
        else           begin st2 = 1'b1; c82 = c8[0]; end
        @(negedge clk);
        st1 = 1'b0;
        st2 = 1'b0;
    endtask

    task automatic wait_fin(input int inst, input string nm);
        int n = 0;
        while (!(inst == 1 ? fin1 : fin2) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " finish"}, int'(inst == 1 ? fin1 : fin2), 1);
        @(negedge clk);
    endtask

    task automatic evaluate(input int inst, input string nm, input int npix, input int cnt,
                            input int ovf, input int uni, input int nmax,
                            input int pa0, input int pl0, input int pa1, input int pl1);
        int bad_w = 0, bad_bg = 0, bad_u = 0, n255 = 0;
        for (int i = 0; i < npix; i++) begin
            if (wcnt[i] != 1) bad_w++;
            if (!img[i] && lbl[i] != 8'd0) bad_bg++;
            if (img[i] && uni != 0 && int'(lbl[i]) != uni) bad_u++;
            if (lbl[i] == 8'd255) n255++;
        end
        chk({nm, " busy"},     int'(inst == 1 ? busy1 : busy2), 0);
        chk({nm, " count"},    int'(inst == 1 ? lc1 : lc2), cnt);
        chk({nm, " overflow"}, int'(inst == 1 ? ovf1 : ovf2), ovf);
        chk({nm, " addrs not written once"}, bad_w, 0);
        chk({nm, " nonzero background"}, bad_bg, 0);
        if (uni != 0) chk({nm, " off-label fg"}, bad_u, 0);
        chk({nm, " pixels at 255"}, n255, nmax);
        chk({nm, " probe0"}, int'(lbl[pa0]), pl0);
        chk({nm, " probe1"}, int'(lbl[pa1]), pl1);
    endtask

    task automatic check_reset_outs(input string nm);
        chk({nm, " busy1"}, int'(busy1), 0);
        chk({nm, " fin1"},  int'(fin1), 0);
        chk({nm, " wen1"},  int'(wen1), 1);
        chk({nm, " sa1"},   int'(sa1), 0);
        chk({nm, " sd1"},   int'(sd1), 0);
        chk({nm, " rom_a1"}, int'(rom_a1), 0);
        chk({nm, " lc1"},   int'(lc1), 0);
        chk({nm, " ovf1"},  int'(ovf1), 0);
        chk({nm, " busy2"}, int'(busy2), 0);
        chk({nm, " wen2"},  int'(wen2), 1);
        chk({nm, " sa2"},   int'(sa2), 0);
        chk({nm, " lc2"},   int'(lc2), 0);
    endtask

    // Abort a U-shaped flood mid-BFS with reset, then rerun it to completion.
    task automatic rst_mid(input int inst, input int w, input int h, input int waitn,
                           input int pa0, input int pa1);
        build(5, w, h);
        clear_mem();
        pulse_start(inst, 0);
        repeat (waitn) @(negedge clk);
        chk("pre-reset busy",  int'(inst == 1 ? busy1 : busy2), 1);
        chk("pre-reset count", int'(inst == 1 ? lc1 : lc2), 1);
        rst = 1'b1;
        #1;
        check_reset_outs("midrst");
        @(negedge clk) rst = 1'b0;
        clear_mem();
        pulse_start(inst, 0);
        wait_fin(inst, "rerun");
        evaluate(inst, "rerun", w*h, 1, 0, 1, 0, pa0, 1, pa1, 1);
    endtask

    initial begin
        v[0] = '{0, 1,   0, 0, 0,   0,   0,   0, 1023,   0};
        v[1] = '{1, 0,   1, 0, 1,   0,   0,   1, 1023,   1};
        v[2] = '{2, 1,   1, 0, 1,   0,   0,   1,   33,   1};
        v[3] = '{2, 0,   2, 0, 0,   0,   0,   1,   33,   2};
        v[4] = '{3, 1,   2, 0, 0,   0,  31,   1,   32,   2};
        v[5] = '{3, 0,   2, 0, 0,   0,  31,   1,   32,   2};
        v[6] = '{4, 0, 255, 1, 0, 258, 507, 254, 1023, 255};
        v[7] = '{4, 1,   1, 0, 1,   0,   0,   1, 1023,   1};
        v[8] = '{5, 0,   1, 0, 1,   0,  34,   1,   38,   1};

        rst = 1'b1; st1 = 1'b0; c81 = 1'b0; st2 = 1'b0; c82 = 1'b0; clr = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outs("reset");
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            build(v[i].pat, 32, 32);
            clear_mem();
            pulse_start(1, v[i].c8);
            chk({nm, " busy after start"}, int'(busy1), 1);
            wait_fin(1, nm);
            evaluate(1, nm, 1024, v[i].cnt, v[i].ovf, v[i].uni, v[i].nmax,
                     v[i].pa0, v[i].pl0, v[i].pa1, v[i].pl1);
        end

        // A second start while busy must not relatch conn8 or restart the run.
        build(2, 32, 32);
        clear_mem();
        pulse_start(1, 0);
        repeat (20) @(negedge clk);
        pulse_start(1, 1);
        wait_fin(1, "ignore-start");
        evaluate(1, "ignore-start", 1024, 2, 0, 0, 0, 0, 1, 33, 2);

        rst_mid(1, 32, 32, 128 + 34 + 3, 34, 38);
        rst_mid(2, 16, 8, 8 + 18 + 3, 18, 22);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end
endmodule
